// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an external host and spi_reg_slave.
interface spi_reg_slave_if;
  logic SCLK;
  logic SSEL;
  logic MOSI;
  logic MISO;

  modport slave  (input SCLK, input SSEL, input MOSI, output MISO);
  modport master (output SCLK, output SSEL, output MOSI, input MISO);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: oversampled 16-bit write/read frames into an 8-bit register bank.
// Optional SHADOW_COMMIT_EN: writes land in a shadow bank copied to regs at vsync pulse start.
module spi_reg_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_reg_slave_if.slave          spi,
  input  logic                    vsync,
  output logic [NUM_REGS*8-1:0]   regs,
  output logic                    wr_strobe,
  output logic [2:0]              wr_addr
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned BANK_W = NUM_REGS * 8;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ssel_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ssel_d;
  logic                   w_sclk, w_ssel, w_mosi;
  logic                   w_sclk_rise, w_sclk_fall, w_ssel_rise, w_ssel_fall;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic [6:0]         r_shift, w_shift_n;
  logic               r_rw, w_rw_n;
  logic [6:0]         r_addr, w_addr_n;
  logic [7:0]         r_rd, w_rd_n;
  logic               r_miso, w_miso_n;
  logic [BANK_W-1:0]  r_bank, w_bank_n;
  logic               r_wr_strobe, w_wr_strobe_n;
  logic [2:0]         r_wr_addr, w_wr_addr_n;
  logic [BANK_W-1:0]  w_rd_src;
  logic [6:0]         w_cmd_addr;
  logic [7:0]         w_wdata;

  // Synchronizers plus one delay flop per line for edge detection; SSEL idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ssel_sync <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ssel_d    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      r_ssel_sync <= {r_ssel_sync[SYNC_STAGES-2:0], spi.SSEL};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      r_sclk_d    <= w_sclk;
      r_ssel_d    <= w_ssel;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ssel      = r_ssel_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk &  r_sclk_d;
  assign w_ssel_rise =  w_ssel & ~r_ssel_d;
  assign w_ssel_fall = ~w_ssel &  r_ssel_d;
  assign w_cmd_addr  = {r_shift[5:0], w_mosi};
  assign w_wdata     = {r_shift, w_mosi};

`ifdef SHADOW_COMMIT_EN
  logic              r_vsync_d;
  logic              w_vsync_rise;
  logic [BANK_W-1:0] r_shadow, w_shadow_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_shadow  <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_shadow  <= w_shadow_n;
    end
  end

  assign w_vsync_rise = vsync & ~r_vsync_d;
  assign w_rd_src     = r_shadow;
`else
  logic w_unused_vsync;
  assign w_unused_vsync = vsync;
  assign w_rd_src       = r_bank;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_rd        <= '0;
      r_miso      <= 1'b0;
      r_bank      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_shift     <= w_shift_n;
      r_rw        <= w_rw_n;
      r_addr      <= w_addr_n;
      r_rd        <= w_rd_n;
      r_miso      <= w_miso_n;
      r_bank      <= w_bank_n;
      r_wr_strobe <= w_wr_strobe_n;
      r_wr_addr   <= w_wr_addr_n;
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_shift_n     = r_shift;
    w_rw_n        = r_rw;
    w_addr_n      = r_addr;
    w_rd_n        = r_rd;
    w_miso_n      = r_miso;
    w_bank_n      = r_bank;
    w_wr_strobe_n = 1'b0;
    w_wr_addr_n   = r_wr_addr;
`ifdef SHADOW_COMMIT_EN
    w_shadow_n    = r_shadow;
    if (w_vsync_rise) w_bank_n = r_shadow;
`endif

    case (r_state)
      S_IDLE: begin
        w_miso_n = 1'b0;
        if (w_ssel_fall) begin
          w_state_n = S_CMD;
          w_cnt_n   = '0;
        end
      end
      S_CMD: begin
        w_miso_n = 1'b0;
        if (w_sclk_rise) begin
          w_shift_n = {r_shift[5:0], w_mosi};
          w_cnt_n   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(7)) begin
            w_rw_n    = r_shift[6];
            w_addr_n  = w_cmd_addr;
            w_rd_n    = '0;
            for (int k = 0; k < int'(NUM_REGS); k++)
              if (w_cmd_addr == 7'(k)) w_rd_n = w_rd_src[8*k +: 8];
            w_state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_sclk_rise) begin
          w_shift_n = {r_shift[5:0], w_mosi};
          w_cnt_n   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(15)) begin
            if (r_rw && (r_addr < 7'(NUM_REGS))) begin
              w_wr_strobe_n = 1'b1;
              w_wr_addr_n   = r_addr[2:0];
            end
            w_state_n = S_DONE;
          end
        end else if (w_sclk_fall) begin
          w_miso_n = r_rw ? 1'b0 : r_rd[7];
          w_rd_n   = {r_rd[6:0], 1'b0};
        end
      end
      S_DONE: begin
        if (w_sclk_fall) w_miso_n = 1'b0;
      end
      default: w_state_n = S_IDLE;
    endcase

    // Commit the data byte into whichever bank holds pending writes.
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (w_wr_strobe_n && (r_addr == 7'(k))) begin
`ifdef SHADOW_COMMIT_EN
        w_shadow_n[8*k +: 8] = w_wdata;
`else
        w_bank_n[8*k +: 8] = w_wdata;
`endif
      end
    end

    if (w_ssel) w_miso_n = 1'b0;
    if (w_ssel_rise) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
    end
  end

  assign regs      = r_bank;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign spi.MISO  = r_miso;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: SPI host tasks plus a write scoreboard fed at stimulus time.
module tb_spi_reg_slave;
  localparam int unsigned NUM_REGS    = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          HALF        = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  vsync;
  logic [NUM_REGS*8-1:0] regs;
  logic                  wr_strobe;
  logic [2:0]            wr_addr;

  spi_reg_slave_if bus ();

  spi_reg_slave #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (bus),
    .vsync     (vsync),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  logic [10:0] exp_q[$];
  logic [63:0] exp_regs;
  logic [63:0] exp_shadow;
  logic [10:0] mon_e;

  // Scoreboard: each wr_strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: wr_addr=%0d, no write expected", wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
`ifdef SHADOW_COMMIT_EN
        if (wr_addr !== mon_e[10:8]) begin
          errors++;
          $display("FAIL strobe_addr: got %0d expected %0d", wr_addr, mon_e[10:8]);
        end
`else
        if ({wr_addr, regs[8*int'(mon_e[10:8]) +: 8]} !== mon_e) begin
          errors++;
          $display("FAIL strobe_write: got addr %0d data %h expected addr %0d data %h",
                   wr_addr, regs[8*int'(mon_e[10:8]) +: 8], mon_e[10:8], mon_e[7:0]);
        end
`endif
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    int idx;
    if (a < 7'(NUM_REGS)) begin
      idx = int'(a[2:0]);
      exp_q.push_back({a[2:0], d});
      exp_shadow[8*idx +: 8] = d;
`ifndef SHADOW_COMMIT_EN
      exp_regs[8*idx +: 8] = d;
`endif
    end
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits,
                           output logic [7:0] rd, output logic miso_end);
    rd = '0;
    bus.SSEL = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = (i < 16) ? f[15-i] : 1'b0;
      wait_clk(HALF);
      if (i >= 8 && i < 16) rd = {rd[6:0], bus.MISO};
      bus.SCLK = 1'b1;
      wait_clk(HALF);
      bus.SCLK = 1'b0;
    end
    wait_clk(HALF);
    miso_end = bus.MISO;
    bus.SSEL = 1'b1;
    bus.MOSI = 1'b0;
    wait_clk(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0;
    bus.SCLK = 1'b0; bus.SSEL = 1'b1; bus.MOSI = 1'b0;
    exp_regs = '0; exp_shadow = '0;
    wait_clk(3);
    checks++; if (regs !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs); end
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.MISO); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    rst_n = 1'b1;
    wait_clk(3);
  endtask

`ifdef SHADOW_COMMIT_EN
  task automatic test_shadow();
    logic [7:0] rd; logic me;
    model_write(7'd0, 8'h33);
    spi_frame(16'h8033, 16, rd, me);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL shadow_strobe: %0d writes missing", exp_q.size()); end
    checks++; if (regs[7:0] !== 8'h00) begin errors++; $display("FAIL shadow_hold: got %h expected 00", regs[7:0]); end
    vsync = 1'b1;
    wait_clk(3);
    exp_regs = exp_shadow;
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL shadow_commit: got %h expected %h", regs, exp_regs); end
    vsync = 1'b0;
    wait_clk(2);
  endtask
`endif

  task automatic test_write();
    logic [7:0] rd; logic me; int sc;
    sc = strobe_cnt;
    model_write(7'd3, 8'h55);
    spi_frame(16'h8355, 16, rd, me);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL write_done: %0d writes missing", exp_q.size()); end
    checks++; if (strobe_cnt - sc != 1) begin errors++; $display("FAIL write_strobes: got %0d expected 1", strobe_cnt - sc); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL write_regs: got %h expected %h", regs, exp_regs); end
    checks++; if (me !== 1'b0) begin errors++; $display("FAIL write_miso_done: got %b expected 0", me); end
  endtask

  task automatic test_read();
    logic [7:0] rd; logic me; int sc;
    model_write(7'd1, 8'hA7);
    spi_frame(16'h81A7, 16, rd, me);
    sc = strobe_cnt;
    spi_frame(16'h0100, 16, rd, me);
    checks++; if (rd !== 8'hA7) begin errors++; $display("FAIL read_data: got %h expected a7", rd); end
    checks++; if (strobe_cnt != sc) begin errors++; $display("FAIL read_strobe: got %0d strobes expected 0", strobe_cnt - sc); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL read_regs: got %h expected %h", regs, exp_regs); end
    checks++; if (me !== 1'b0) begin errors++; $display("FAIL read_miso_done: got %b expected 0", me); end
  endtask

  task automatic test_short_frame();
    logic [7:0] rd; logic me; int sc;
    sc = strobe_cnt;
    spi_frame(16'h82FF, 12, rd, me);
    checks++; if (strobe_cnt != sc) begin errors++; $display("FAIL short_strobe: got %0d strobes expected 0", strobe_cnt - sc); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL short_regs: got %h expected %h", regs, exp_regs); end
    model_write(7'd2, 8'h11);
    spi_frame(16'h8211, 16, rd, me);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_next_done: %0d writes missing", exp_q.size()); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL short_next_regs: got %h expected %h", regs, exp_regs); end
  endtask

  task automatic test_extra_pulses();
    logic [7:0] rd; logic me; int sc;
    sc = strobe_cnt;
    model_write(7'd4, 8'h12);
    spi_frame(16'h8412, 20, rd, me);
    checks++; if (strobe_cnt - sc != 1) begin errors++; $display("FAIL extra_strobes: got %0d expected 1", strobe_cnt - sc); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL extra_regs: got %h expected %h", regs, exp_regs); end
    checks++; if (me !== 1'b0) begin errors++; $display("FAIL extra_miso_done: got %b expected 0", me); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rd; logic me; int sc;
    sc = strobe_cnt;
    spi_frame(16'h8966, 16, rd, me);
    spi_frame(16'h0900, 16, rd, me);
    checks++; if (strobe_cnt != sc) begin errors++; $display("FAIL oor_strobe: got %0d strobes expected 0", strobe_cnt - sc); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL oor_regs: got %h expected %h", regs, exp_regs); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL oor_read: got %h expected 00", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic me; logic [2:0] a; logic [7:0] d;
    for (int n = 0; n < 6; n++) begin
      a = 3'($urandom_range(0, NUM_REGS - 1));
      d = 8'($urandom_range(0, 255));
      model_write({4'b0, a}, d);
      spi_frame({1'b1, 4'b0000, a, d}, 16, rd, me);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_done: %0d writes missing", exp_q.size()); end
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      spi_frame({1'b0, 4'b0000, 3'(k), 8'h00}, 16, rd, me);
      checks++;
      if (rd !== exp_shadow[8*k +: 8]) begin
        errors++;
        $display("FAIL b2b_read reg%0d: got %h expected %h", k, rd, exp_shadow[8*k +: 8]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] f; logic [7:0] rd; logic me;
    f = 16'h8577;
    bus.SSEL = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 10; i++) begin
      bus.MOSI = f[15-i];
      wait_clk(HALF);
      bus.SCLK = 1'b1;
      wait_clk(HALF);
      bus.SCLK = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (regs !== 64'h0) begin errors++; $display("FAIL midrst_regs: got %h expected 0", regs); end
    checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", bus.MISO); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL midrst_strobe: got %b expected 0", wr_strobe); end
    checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL midrst_wr_addr: got %0d expected 0", wr_addr); end
    bus.SSEL = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    exp_regs = '0; exp_shadow = '0; exp_q.delete();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    model_write(7'd5, 8'h77);
    spi_frame(16'h8577, 16, rd, me);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_recover: %0d writes missing", exp_q.size()); end
    checks++; if (regs !== exp_regs) begin errors++; $display("FAIL midrst_regs_after: got %h expected %h", regs, exp_regs); end
  endtask

  initial begin
    test_reset();
`ifdef SHADOW_COMMIT_EN
    test_shadow();
`endif
    test_write();
    test_read();
    test_short_frame();
    test_extra_pulses();
    test_out_of_range();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
